// File: rtl/fdu_nchan_if.sv
// fdu_nchan_if: board-side bundle of the N-channel fault detection unit.
//   master : heartbeat/inject driver side (board, bench)
//   slave  : the fault detection unit
// Signals
//   hb        NCH*HB_W  heartbeat buses, channel i at [i*HB_W +: HB_W]
//   err_sw    NCH       level error inject
//   err_pulse NCH       asynchronous error-inject request (rising edge latches)
//   health    NCH       registered per-channel health
//   prime     NCH       one-hot prime select, all zero = no prime
//   prime_idx IDX_W     index of prime channel, 0 when there is none
//   por       NCH       active-high POR pulse per channel
//   failed    NCH       sticky retries-exhausted flag
//   fsm_state 2         prime FSM state (IDLE 00, STARTUP 01, PRIME 10)
interface fdu_nchan_if #(
  parameter int NCH  = 4,
  parameter int HB_W = 3
);
  localparam int IDX_W = $clog2(NCH);

  logic [NCH*HB_W-1:0] hb;
  logic [NCH-1:0]      err_sw;
  logic [NCH-1:0]      err_pulse;
  logic [NCH-1:0]      health;
  logic [NCH-1:0]      prime;
  logic [IDX_W-1:0]    prime_idx;
  logic [NCH-1:0]      por;
  logic [NCH-1:0]      failed;
  logic [1:0]          fsm_state;

  modport master (
    output hb, err_sw, err_pulse,
    input  health, prime, prime_idx, por, failed, fsm_state
  );

  modport slave (
    input  hb, err_sw, err_pulse,
    output health, prime, prime_idx, por, failed, fsm_state
  );
endinterface

// File: rtl/fdu_nchan.sv
// fdu_nchan: N-channel fault detection unit.
// Watches a heartbeat bus per redundant channel, derives registered health,
// elects one healthy channel as prime and issues a bounded number of POR
// pulses to any channel that drops out. Per-channel error injection freezes a
// channel's heartbeat sample so the fault response can be exercised.
//
// Ports
//   clk    system clock
//   reset  asynchronous, active-high
//   bus    fdu_nchan_if.slave (hb, err_sw, err_pulse in; health, prime,
//          prime_idx, por, failed, fsm_state out). bus parameters must match
//          NCH/HB_W here.
//
// Build option
//   FDU_NCHAN_REVERT_EN  when defined, prime returns to channel 0 after it has
//                        been eligible for REVERT_HOLD consecutive cycles.
//                        Undefined: prime is strictly sticky.

// Per-channel watchdog, inject latch and POR retry sequencer.
module fdu_nchan_ch #(
  parameter int HB_W          = 3,
  parameter int HB_TIMEOUT    = 250000000,
  parameter int POR_CYCLES    = 50000000,
  parameter int POR_MAX_RETRY = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [HB_W-1:0] hb,
  input  logic            err_sw,
  input  logic            err_pulse,
  output logic            health,
  output logic            por,
  output logic            failed
);
  localparam int WD_W  = $clog2(HB_TIMEOUT + 1);
  localparam int POR_W = $clog2(POR_CYCLES + 1);
  localparam int RT_W  = (POR_MAX_RETRY > 0) ? $clog2(POR_MAX_RETRY + 1) : 1;

  logic [2:0]       sync_q, sync_d;
  logic             latch_q, latch_d;
  logic [HB_W-1:0]  hb_s_q, hb_s_d;
  logic [HB_W-1:0]  hb_p_q, hb_p_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             health_q, health_d;
  logic             health_p_q, health_p_d;
  logic [POR_W-1:0] pcnt_q, pcnt_d;
  logic             por_q, por_d;
  logic [RT_W-1:0]  retry_q, retry_d;
  logic             failed_q, failed_d;
  logic             inject;
  logic             fall;

  always_comb begin
    // sync_q[1:0] is the 2-flop synchroniser, sync_q[2] the edge-detect delay.
    sync_d  = {sync_q[1:0], err_pulse};
    latch_d = latch_q | (sync_q[1] & ~sync_q[2]);
    inject  = err_sw | latch_q;

    // An injected channel keeps its last sample, so the watchdog sees silence.
    hb_s_d = inject ? hb_s_q : hb;
    hb_p_d = hb_s_q;

    wd_d     = wd_q;
    health_d = health_q;
    if (hb_s_q != hb_p_q) begin
      wd_d     = '0;
      health_d = 1'b1;
    end else begin
      if (wd_q != WD_W'(HB_TIMEOUT)) wd_d = wd_q + 1'b1;
      if (wd_q == WD_W'(HB_TIMEOUT - 1)) health_d = 1'b0;
    end

    health_p_d = health_q;
    fall       = health_p_q & ~health_q;

    por_d    = por_q;
    pcnt_d   = pcnt_q;
    retry_d  = retry_q;
    failed_d = failed_q;
    if (por_q) begin
      // Falls during an active pulse are ignored: this branch wins.
      if (pcnt_q == POR_W'(POR_CYCLES - 1)) por_d = 1'b0;
      else                                  pcnt_d = pcnt_q + 1'b1;
    end else if (fall && !failed_q) begin
      if (retry_q < RT_W'(POR_MAX_RETRY)) begin
        por_d   = 1'b1;
        pcnt_d  = '0;
        retry_d = retry_q + 1'b1;
      end else begin
        failed_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q     <= '0;
      latch_q    <= 1'b0;
      hb_s_q     <= '0;
      hb_p_q     <= '0;
      wd_q       <= '0;
      health_q   <= 1'b0;
      health_p_q <= 1'b0;
      pcnt_q     <= '0;
      por_q      <= 1'b0;
      retry_q    <= '0;
      failed_q   <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      latch_q    <= latch_d;
      hb_s_q     <= hb_s_d;
      hb_p_q     <= hb_p_d;
      wd_q       <= wd_d;
      health_q   <= health_d;
      health_p_q <= health_p_d;
      pcnt_q     <= pcnt_d;
      por_q      <= por_d;
      retry_q    <= retry_d;
      failed_q   <= failed_d;
    end
  end

  assign health = health_q;
  assign por    = por_q;
  assign failed = failed_q;
endmodule

module fdu_nchan #(
  parameter int NCH             = 4,
  parameter int HB_W            = 3,
  parameter int HB_TIMEOUT      = 250000000,
  parameter int STARTUP_TIMEOUT = 250000000,
  parameter int POR_CYCLES      = 50000000,
  parameter int POR_MAX_RETRY   = 3,
  parameter int REVERT_HOLD     = 50000000
) (
  input  logic        clk,
  input  logic        reset,
  fdu_nchan_if.slave  bus
);
  localparam int IDX_W = $clog2(NCH);
  localparam int SU_W  = $clog2(STARTUP_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_STARTUP = 2'b01,
    ST_PRIME   = 2'b10
  } state_e;

  logic [NCH-1:0]   health, por, failed;
  logic [NCH-1:0]   elig, alt_mask;
  logic             low_vld, alt_vld;
  logic [IDX_W-1:0] low_idx, alt_idx;
  logic             su_exp;

  state_e           state_q;
  logic             boot_q;
  logic [IDX_W-1:0] idx_q;
  logic [NCH-1:0]   prime_q;
  logic [SU_W-1:0]  su_q;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    fdu_nchan_ch #(
      .HB_W          (HB_W),
      .HB_TIMEOUT    (HB_TIMEOUT),
      .POR_CYCLES    (POR_CYCLES),
      .POR_MAX_RETRY (POR_MAX_RETRY)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .hb        (bus.hb[i*HB_W +: HB_W]),
      .err_sw    (bus.err_sw[i]),
      .err_pulse (bus.err_pulse[i]),
      .health    (health[i]),
      .por       (por[i]),
      .failed    (failed[i])
    );
  end

  // A channel in POR is never eligible, even if its heartbeat is back.
  assign elig   = health & ~failed & ~por;
  assign su_exp = (su_q == SU_W'(STARTUP_TIMEOUT));

  // Lowest eligible channel, overall and excluding the current prime.
  always_comb begin
    alt_mask        = elig;
    alt_mask[idx_q] = 1'b0;
    low_vld = 1'b0;
    low_idx = '0;
    alt_vld = 1'b0;
    alt_idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (elig[i]) begin
        low_vld = 1'b1;
        low_idx = IDX_W'(i);
      end
      if (alt_mask[i]) begin
        alt_vld = 1'b1;
        alt_idx = IDX_W'(i);
      end
    end
  end

`ifdef FDU_NCHAN_REVERT_EN
  localparam int HOLD_W = $clog2(REVERT_HOLD + 1);
  logic [HOLD_W-1:0] hold_q;
`endif

  // The state register comes out of reset as IDLE so every output reads 0
  // while reset is held; boot_q steers the first edge into STARTUP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      boot_q  <= 1'b1;
      idx_q   <= '0;
      prime_q <= '0;
      su_q    <= '0;
`ifdef FDU_NCHAN_REVERT_EN
      hold_q  <= '0;
`endif
    end else begin
      if (!su_exp) su_q <= su_q + 1'b1;
      prime_q <= (state_q == ST_PRIME) ? (NCH'(1) << idx_q) : '0;
`ifdef FDU_NCHAN_REVERT_EN
      hold_q <= '0;
      if (state_q == ST_PRIME && idx_q != '0 && elig[0])
        hold_q <= (hold_q == HOLD_W'(REVERT_HOLD)) ? hold_q : hold_q + 1'b1;
`endif
      case (state_q)
        ST_IDLE: begin
          if (boot_q) begin
            boot_q  <= 1'b0;
            state_q <= ST_STARTUP;
          end else if (low_vld) begin
            state_q <= ST_PRIME;
            idx_q   <= low_idx;
          end
        end
        ST_STARTUP: begin
          // Channel 0 may take prime at once; others wait for the timer.
          if (elig[0]) begin
            state_q <= ST_PRIME;
            idx_q   <= '0;
          end else if (su_exp && low_vld) begin
            state_q <= ST_PRIME;
            idx_q   <= low_idx;
          end
        end
        ST_PRIME: begin
          if (!health[idx_q]) begin
            if (alt_vld) begin
              idx_q <= alt_idx;
            end else begin
              state_q <= ST_IDLE;
              idx_q   <= '0;
            end
          end
`ifdef FDU_NCHAN_REVERT_EN
          else if (idx_q != '0 && elig[0] && hold_q == HOLD_W'(REVERT_HOLD)) begin
            idx_q <= '0;
          end
`endif
        end
        default: begin
          state_q <= ST_IDLE;
          idx_q   <= '0;
        end
      endcase
    end
  end

  assign bus.health    = health;
  assign bus.por       = por;
  assign bus.failed    = failed;
  assign bus.prime     = prime_q;
  assign bus.prime_idx = idx_q;
  assign bus.fsm_state = state_q;
endmodule

// File: tb/tb_fdu_nchan.sv
// tb_fdu_nchan: directed bench for fdu_nchan with short timeouts
// (HB_TIMEOUT 16, STARTUP_TIMEOUT 64, POR_CYCLES 8, POR_MAX_RETRY 2,
// REVERT_HOLD 32). Heartbeats are advanced on the falling edge; outputs are
// read on the falling edge, half a cycle after the registers move.
module tb_fdu_nchan;
  localparam int NCH  = 4;
  localparam int HB_W = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fdu_nchan_if #(.NCH(NCH), .HB_W(HB_W)) bus ();

  fdu_nchan #(
    .NCH             (NCH),
    .HB_W            (HB_W),
    .HB_TIMEOUT      (16),
    .STARTUP_TIMEOUT (64),
    .POR_CYCLES      (8),
    .POR_MAX_RETRY   (2),
    .REVERT_HOLD     (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp;
  int n_bad;
  logic [HB_W-1:0] hbv [NCH];
  logic [NCH-1:0]  run;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic drive_hb();
    for (int i = 0; i < NCH; i++) bus.hb[i*HB_W +: HB_W] = hbv[i];
  endtask

  // One clock: advance every running heartbeat on the falling edge.
  task automatic step();
    @(negedge clk);
    for (int i = 0; i < NCH; i++) if (run[i]) hbv[i] = hbv[i] + 1'b1;
    drive_hb();
  endtask

  // Steps until health[ch] reads low; k = steps taken (40 = never fell).
  task automatic wait_fall(input int ch, output int k);
    k = 0;
    while (bus.health[ch] && k < 40) begin
      step();
      k++;
    end
  endtask

  task automatic por_len(input int ch, input int n, output int pc);
    pc = 0;
    repeat (n) begin
      step();
      if (bus.por[ch]) pc++;
    end
  endtask

  // Asserts reset between edges: outputs must clear without a clock edge.
  task automatic do_reset();
    reset = 1'b1;
    run = '0;
    bus.err_sw = '0;
    bus.err_pulse = '0;
    for (int i = 0; i < NCH; i++) hbv[i] = '0;
    drive_hb();
    #1;
    chk("rst_out", {bus.health, bus.prime, bus.por, bus.failed, bus.fsm_state, bus.prime_idx}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int k;
    int pc;
    n_cmp = 0;
    n_bad = 0;

    // All channels alive: health at cycle 3, prime(0) at cycle 5.
    do_reset();
    run = '1;
    step(); step();
    chk("h_early", bus.health, 4'h0);
    step();
    chk("h_all", bus.health, 4'hF);
    chk("fsm_su", bus.fsm_state, 2'b01);
    step();
    chk("fsm_prime", bus.fsm_state, 2'b10);
    chk("prime_lag", bus.prime, 4'h0);
    step();
    chk("prime0", bus.prime, 4'b0001);
    chk("idx0", bus.prime_idx, 0);

    // Freeze the prime: fail over to ch1, POR ch0 for 8 cycles.
    run[0] = 1'b0;
    wait_fall(0, k);
    chk("h0_fall", k, 18);
    pc = 0;
    for (int j = 1; j <= 12; j++) begin
      step();
      if (bus.por[0]) pc++;
      if (j == 1) begin
        chk("idx_fo", bus.prime_idx, 1);
        chk("por0_rise", bus.por, 4'b0001);
      end
      if (j == 2) chk("prime_fo", bus.prime, 4'b0010);
    end
    chk("por0_len", pc, 8);

    // ch0 recovers while ch1 is prime.
    run[0] = 1'b1;
    repeat (20) step();
    chk("no_revert_yet", bus.prime, 4'b0010);
    repeat (30) step();
`ifdef FDU_NCHAN_REVERT_EN
    chk("revert", bus.prime, 4'b0001);
`else
    chk("sticky", bus.prime, 4'b0010);
`endif

    // Reset in the middle of a POR pulse.
    run[2] = 1'b0;
    wait_fall(2, k);
    step();
    chk("por2_on", bus.por[2], 1);
    do_reset();

    // Only ch2 alive: no prime until startup timer expires.
    run = 4'b0100;
    repeat (60) step();
    chk("su_hold", bus.prime, 4'h0);
    chk("su_fsm", bus.fsm_state, 2'b01);
    chk("su_health", bus.health, 4'b0100);
    repeat (5) step();
    chk("su_exp_fsm", bus.fsm_state, 2'b10);
    chk("su_exp_idx", bus.prime_idx, 2);
    chk("su_exp_lag", bus.prime, 4'h0);
    step();
    chk("su_prime2", bus.prime, 4'b0100);

    // Lose the only channel: IDLE, then re-prime after its POR.
    run[2] = 1'b0;
    wait_fall(2, k);
    chk("h2_fall", k, 18);
    step();
    chk("idle_fsm", bus.fsm_state, 2'b00);
    chk("idle_idx", bus.prime_idx, 0);
    step();
    chk("idle_prime", bus.prime, 4'h0);
    run[2] = 1'b1;
    repeat (15) step();
    chk("idle_reprime", bus.prime, 4'b0100);

    // ch1 dies three times: two PORs, then failed.
    do_reset();
    run = '1;
    repeat (6) step();
    for (int r = 0; r < 3; r++) begin
      run[1] = 1'b0;
      wait_fall(1, k);
      chk("h1_fall", k, 18);
      por_len(1, 12, pc);
      chk("por1_len", pc, (r < 2) ? 8 : 0);
      run[1] = 1'b1;
      repeat (6) step();
    end
    chk("failed1", bus.failed, 4'b0010);
    chk("prime_keep", bus.prime, 4'b0001);
    chk("h1_back", bus.health[1], 1);
    run[0] = 1'b0;
    wait_fall(0, k);
    step(); step();
    chk("skip_failed", bus.prime, 4'b0100);

    // Prime and next candidate die in the same cycle.
    do_reset();
    run = '1;
    repeat (6) step();
    run[0] = 1'b0;
    run[1] = 1'b0;
    wait_fall(0, k);
    chk("h01_fall", bus.health, 4'b1100);
    step(); step();
    chk("sim_fail", bus.prime, 4'b0100);

    // One-cycle err_pulse on ch3 latches an inject.
    do_reset();
    run = '1;
    repeat (6) step();
    bus.err_pulse[3] = 1'b1;
    step();
    bus.err_pulse[3] = 1'b0;
    k = 1;
    while (bus.health[3] && k < 40) begin
      step();
      k++;
    end
    chk("pulse_fall", k, 20);
    repeat (10) step();
    chk("pulse_stick", bus.health[3], 0);

    // Level err_sw on ch3.
    do_reset();
    run = '1;
    repeat (6) step();
    bus.err_sw[3] = 1'b1;
    wait_fall(3, k);
    chk("sw_fall", k, 17);
    repeat (10) step();
    chk("sw_hold", bus.health[3], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end
endmodule
